// File: rtl/conc_decode.sv
// Streaming inverse of the Conc block: recovers (i, j) from (a, b, c, d, e),
// flags inconsistent tuples and counts errored deliveries (saturating).
module conc_decode #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [WIDTH-1:0]     c,
   input  logic [WIDTH-1:0]     d,
   input  logic [WIDTH-1:0]     e,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     i,
   output logic [WIDTH-1:0]     j,
   output logic [3:0]           err,
   output logic [CNT_WIDTH-1:0] err_cnt
);

   localparam logic [WIDTH-1:0]     FIVE    = WIDTH'(5);
   localparam logic [WIDTH-1:0]     SIX     = WIDTH'(6);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic                 s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]     s1_i_q, s1_i_d;
   logic [WIDTH-1:0]     s1_j_q, s1_j_d;
   logic [3:0]           s1_err_q, s1_err_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0]     s2_i_q, s2_i_d;
   logic [WIDTH-1:0]     s2_j_q, s2_j_d;
   logic [3:0]           s2_err_q, s2_err_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   logic [WIDTH-1:0] three_a, four_a, a_m6;
   logic [3:0]       chk_err;
   logic             s2_load, s1_adv, in_rdy, in_fire, out_fire;

   // Consistency checks on the incoming tuple, plus handshake/advance control
   always_comb begin
      three_a  = a + {a[WIDTH-2:0], 1'b0};
      four_a   = {a[WIDTH-3:0], 2'b00};
      a_m6     = a - SIX;
      chk_err  = {|e[WIDTH-1:WIDTH-2], d != a_m6, c != four_a, b != three_a};

      s2_load  = !s2_valid_q || out_ready;
      s1_adv   = s1_valid_q && s2_load;
      in_rdy   = rst && (!s1_valid_q || s2_load);
      in_fire  = in_valid && in_rdy;
      out_fire = s2_valid_q && out_ready;

      s1_valid_d = s1_valid_q;
      s1_i_d     = s1_i_q;
      s1_j_d     = s1_j_q;
      s1_err_d   = s1_err_q;
      s2_valid_d = s2_valid_q;
      s2_i_d     = s2_i_q;
      s2_j_d     = s2_j_q;
      s2_err_d   = s2_err_q;
      err_cnt_d  = err_cnt_q;

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_i_d     = a - FIVE;
         s1_j_d     = {e[WIDTH-3:0], 2'b00};
         s1_err_d   = chk_err;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         s2_valid_d = 1'b1;
         s2_i_d     = s1_i_q;
         s2_j_d     = s1_j_q;
         s2_err_d   = s1_err_q;
      end else if (out_fire) begin
         s2_valid_d = 1'b0;
      end

      // Counts delivered tuples only; sticks at the maximum
      if (out_fire && (s2_err_q != 4'd0) && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_i_q     <= '0;
         s1_j_q     <= '0;
         s1_err_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_i_q     <= '0;
         s2_j_q     <= '0;
         s2_err_q   <= '0;
         err_cnt_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_i_q     <= s1_i_d;
         s1_j_q     <= s1_j_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         s2_i_q     <= s2_i_d;
         s2_j_q     <= s2_j_d;
         s2_err_q   <= s2_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign in_ready  = in_rdy;
   assign out_valid = s2_valid_q;
   assign i         = s2_i_q;
   assign j         = s2_j_q;
   assign err       = s2_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_conc_decode.sv
// Directed bench for conc_decode: vector table for recovery/check flags,
// plus sequences for backpressure, counter saturation and mid-stream reset.
module tb_conc_decode;

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0, b = '0, c = '0, d = '0, e = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  i, j;
   logic [3:0]    err;
   logic [CW-1:0] err_cnt;

   conc_decode #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .d(d), .e(e),
      .out_valid(out_valid), .out_ready(out_ready),
      .i(i), .j(j), .err(err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a, b, c, d, e;
      logic [W-1:0] exp_i, exp_j;
      logic [3:0]   exp_err;
   } vec_t;

   vec_t vecs[9];
   int   n_vec = 0;
   int   n_bad = 0;
   int   exp_cnt = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [W-1:0] va, vb, vc, vd, ve);
      a = va; b = vb; c = vc; d = vd; e = ve;
   endtask

   initial begin
      int idx, out_idx, cyc;
      logic [W-1:0] held_i;
      logic stale;

      vecs[0] = '{32'd15, 32'd45, 32'd60, 32'd9, 32'd25, 32'd10, 32'd100, 4'b0000};
      vecs[1] = '{32'd3, 32'd9, 32'd12, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFE, 32'd0, 4'b0000};
      vecs[2] = '{32'd15, 32'd46, 32'd60, 32'd9, 32'd25, 32'd10, 32'd100, 4'b0001};
      vecs[3] = '{32'd15, 32'd45, 32'd60, 32'd9, 32'h4000_0000, 32'd10, 32'd0, 4'b1000};
      vecs[4] = '{32'd15, 32'd45, 32'd61, 32'd9, 32'd25, 32'd10, 32'd100, 4'b0010};
      vecs[5] = '{32'd15, 32'd45, 32'd60, 32'd8, 32'd25, 32'd10, 32'd100, 4'b0100};
      vecs[6] = '{32'd15, 32'd0, 32'd0, 32'd0, 32'hC000_0000, 32'd10, 32'd0, 4'b1111};
      vecs[7] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFA, 32'h3FFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 4'b0000};
      vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFF9, 32'd1, 32'hFFFF_FFFA, 32'd4, 4'b0000};

      // Reset state while held
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", W'(out_valid), 32'd0);
      chk("rst_in_ready",  W'(in_ready),  32'd0);
      chk("rst_i",         i,             32'd0);
      chk("rst_j",         j,             32'd0);
      chk("rst_err",       W'(err),       32'd0);
      chk("rst_err_cnt",   W'(err_cnt),   32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", W'(in_ready), 32'd1);

      // Table: one tuple at a time with out_ready high
      for (int k = 0; k < 9; k++) begin
         out_ready = 1'b1;
         drive(vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].d, vecs[k].e);
         in_valid = 1'b1;
         #1;
         chk($sformatf("v%0d_in_ready", k), W'(in_ready), 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("v%0d_out_valid", k), W'(out_valid), 32'd1);
         chk($sformatf("v%0d_i", k),   i,        vecs[k].exp_i);
         chk($sformatf("v%0d_j", k),   j,        vecs[k].exp_j);
         chk($sformatf("v%0d_err", k), W'(err),  W'(vecs[k].exp_err));
         @(posedge clk); #1;
         if (vecs[k].exp_err != 4'd0 && exp_cnt < 3) exp_cnt++;
         chk($sformatf("v%0d_err_cnt", k), W'(err_cnt), W'(exp_cnt));
         chk($sformatf("v%0d_drained", k), W'(out_valid), 32'd0);
      end

      // Backpressure: 5 clean tuples i=0..4, out_ready low for 4 cycles
      idx = 0; out_idx = 0; held_i = '0;
      for (cyc = 0; cyc < 40 && out_idx < 5; cyc++) begin
         out_ready = (cyc >= 4);
         in_valid  = (idx < 5);
         drive(W'(idx + 5), W'(3 * (idx + 5)), W'(4 * (idx + 5)), W'(idx - 1), 32'd0);
         #1;
         if (cyc == 2 || cyc == 3) begin
            chk($sformatf("bp_in_ready_c%0d", cyc), W'(in_ready), 32'd0);
            chk($sformatf("bp_accepted_c%0d", cyc), W'(idx), 32'd2);
            chk($sformatf("bp_hold_valid_c%0d", cyc), W'(out_valid), 32'd1);
            chk($sformatf("bp_hold_i_c%0d", cyc), i, 32'd0);
            if (cyc == 3) chk("bp_hold_stable", i, held_i);
            held_i = i;
         end
         if (out_valid && out_ready) begin
            chk($sformatf("bp_out%0d_i", out_idx), i, W'(out_idx));
            chk($sformatf("bp_out%0d_err", out_idx), W'(err), 32'd0);
            out_idx++;
         end
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_all_delivered", W'(out_idx), 32'd5);
      chk("bp_cnt_saturated", W'(err_cnt), 32'd3);

      // Saturated counter plus another errored delivery
      out_ready = 1'b1;
      drive(32'd15, 32'd46, 32'd60, 32'd9, 32'd25);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("sat_hold", W'(err_cnt), 32'd3);

      // Mid-stream reset with two errored tuples in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("mid_full_in_ready", W'(in_ready), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_out_valid", W'(out_valid), 32'd0);
      chk("mid_rst_err_cnt",   W'(err_cnt),   32'd0);
      chk("mid_rst_err",       W'(err),       32'd0);
      rst = 1'b1;
      out_ready = 1'b1;
      stale = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1'b1;
      end
      chk("mid_no_stale", W'(stale), 32'd0);
      chk("mid_in_ready", W'(in_ready), 32'd1);
      chk("mid_cnt_still_zero", W'(err_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
